// File: rtl/axi_read_burst_collector.sv
// axi_read_burst_collector
//
// Collects 16-beat INCR read bursts from one AXI R channel into a small beat
// FIFO for user logic. Tracks outstanding AR requests, frames bursts with an
// internal beat counter, and raises sticky error flags for bad responses, bad
// IDs, RLAST misplacement, unexpected beats and outstanding-count overflow.
//
// Ports:
//   AXI_ACLK, AXI_ARESET          clock, async active-high reset
//   ar_issue                      pulse per accepted AR handshake
//   AXI_R*                        R channel (RREADY is an output)
//   rd_data/resp/last/valid/ready user-side FIFO head and pop handshake
//   burst_done                    pulse after a burst's final beat is accepted
//   outstanding                   bursts issued but not yet completed
//   err_*                         sticky error flags, err_clear clears them
module axi_read_burst_collector #(
  parameter int unsigned      DATA_W     = 256,
  parameter int unsigned      ID_W       = 6,
  parameter int unsigned      BURST_LEN  = 16,
  parameter int unsigned      FIFO_DEPTH = 4,
  parameter logic [ID_W-1:0]  EXP_ID     = '0,
  parameter int unsigned      MAX_OUTST  = 16
) (
  input  logic              AXI_ACLK,
  input  logic              AXI_ARESET,
  input  logic              ar_issue,
  input  logic [DATA_W-1:0] AXI_RDATA,
  input  logic [1:0]        AXI_RRESP,
  input  logic              AXI_RLAST,
  input  logic              AXI_RVALID,
  input  logic [ID_W-1:0]   AXI_RID,
  output logic              AXI_RREADY,
  output logic [DATA_W-1:0] rd_data,
  output logic [1:0]        rd_resp,
  output logic              rd_last,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic              burst_done,
  output logic [4:0]        outstanding,
  output logic              err_resp,
  output logic              err_last,
  output logic              err_id,
  output logic              err_unexp,
  output logic              err_ovf,
  input  logic              err_clear
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = $clog2(BURST_LEN);

  logic [DATA_W-1:0] mem_data [FIFO_DEPTH];
  logic [1:0]        mem_resp [FIFO_DEPTH];
  logic              mem_last [FIFO_DEPTH];

  logic [PTR_W-1:0] wptr_q, rptr_q;
  logic [PTR_W:0]   count_q, count_d;
  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic [4:0]       outst_q, outst_d;
  logic             burst_done_q;
  logic [4:0]       err_q, err_d, err_evt;

  logic beat_acc, have_outst, push, pop, last_idx, final_beat, ovf_evt;

  assign AXI_RREADY = (count_q != (PTR_W+1)'(FIFO_DEPTH));
  assign rd_valid   = (count_q != '0);

  assign beat_acc   = AXI_RVALID & AXI_RREADY;
  assign have_outst = (outst_q != '0);
  // Beats arriving with nothing outstanding are dropped, not framed.
  assign push       = beat_acc & have_outst;
  assign pop        = rd_valid & rd_ready;
  assign last_idx   = (beat_cnt_q == CNT_W'(BURST_LEN - 1));
  assign final_beat = push & last_idx;

  // Head is gated so idle outputs read as zero rather than stale entries.
  assign rd_data = rd_valid ? mem_data[rptr_q] : '0;
  assign rd_resp = rd_valid ? mem_resp[rptr_q] : '0;
  assign rd_last = rd_valid ? mem_last[rptr_q] : 1'b0;

  assign burst_done  = burst_done_q;
  assign outstanding = outst_q;
  assign {err_resp, err_last, err_id, err_unexp, err_ovf} = err_q;

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + (PTR_W+1)'(1);
      2'b01:   count_d = count_q - (PTR_W+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    beat_cnt_d = beat_cnt_q;
    if (push) beat_cnt_d = last_idx ? '0 : beat_cnt_q + CNT_W'(1);
  end

  always_comb begin
    outst_d = outst_q;
    ovf_evt = 1'b0;
    if (ar_issue && !final_beat) begin
      if (outst_q == 5'(MAX_OUTST)) ovf_evt = 1'b1;
      else                          outst_d = outst_q + 5'd1;
    end else if (!ar_issue && final_beat) begin
      outst_d = outst_q - 5'd1;
    end
  end

  always_comb begin
    err_evt = {beat_acc & AXI_RRESP[1],
               beat_acc & (AXI_RLAST != last_idx),
               beat_acc & (AXI_RID != EXP_ID),
               beat_acc & ~have_outst,
               ovf_evt};
    // A new event in the same cycle as err_clear keeps the flag set.
    err_d = err_evt | (err_q & {5{~err_clear}});
  end

  always_ff @(posedge AXI_ACLK or posedge AXI_ARESET) begin
    if (AXI_ARESET) begin
      wptr_q       <= '0;
      rptr_q       <= '0;
      count_q      <= '0;
      beat_cnt_q   <= '0;
      outst_q      <= '0;
      burst_done_q <= 1'b0;
      err_q        <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + PTR_W'(1);
      if (pop)  rptr_q <= rptr_q + PTR_W'(1);
      count_q      <= count_d;
      beat_cnt_q   <= beat_cnt_d;
      outst_q      <= outst_d;
      burst_done_q <= final_beat;
      err_q        <= err_d;
    end
  end

  // Storage needs no reset: entries are only visible while counted valid.
  always_ff @(posedge AXI_ACLK) begin
    if (push) begin
      mem_data[wptr_q] <= AXI_RDATA;
      mem_resp[wptr_q] <= AXI_RRESP;
      mem_last[wptr_q] <= last_idx;
    end
  end

endmodule

// File: tb/tb_axi_read_burst_collector.sv
module tb_axi_read_burst_collector;

  logic         clk = 1'b0;
  logic         arst;
  logic         ar_issue;
  logic [255:0] rdata;
  logic [1:0]   rresp;
  logic         rlast, rvalid, rready;
  logic [5:0]   rid;
  logic [255:0] rd_data;
  logic [1:0]   rd_resp;
  logic         rd_last, rd_valid, rd_ready, burst_done;
  logic [4:0]   outstanding;
  logic         err_resp, err_last, err_id, err_unexp, err_ovf, err_clear;
  logic [4:0]   errs;

  int checks = 0;
  int errors = 0;

  logic [31:0] q_data[$];
  logic        q_last[$];
  logic [1:0]  q_resp[$];
  int          bd_cnt;

  always #5 clk = ~clk;

  assign errs = {err_resp, err_last, err_id, err_unexp, err_ovf};

  axi_read_burst_collector dut (
    .AXI_ACLK(clk), .AXI_ARESET(arst), .ar_issue(ar_issue),
    .AXI_RDATA(rdata), .AXI_RRESP(rresp), .AXI_RLAST(rlast), .AXI_RVALID(rvalid),
    .AXI_RID(rid), .AXI_RREADY(rready),
    .rd_data(rd_data), .rd_resp(rd_resp), .rd_last(rd_last), .rd_valid(rd_valid),
    .rd_ready(rd_ready), .burst_done(burst_done), .outstanding(outstanding),
    .err_resp(err_resp), .err_last(err_last), .err_id(err_id), .err_unexp(err_unexp),
    .err_ovf(err_ovf), .err_clear(err_clear)
  );

  // Pop monitor: record every head that is popped at the coming edge.
  always @(negedge clk) begin
    if (!arst && rd_valid && rd_ready) begin
      q_data.push_back(rd_data[31:0]);
      q_last.push_back(rd_last);
      q_resp.push_back(rd_resp);
    end
    if (!arst && burst_done) bd_cnt++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    q_data.delete();
    q_last.delete();
    q_resp.delete();
    bd_cnt = 0;
  endtask

  task automatic do_reset();
    arst = 1'b1; ar_issue = 0; rdata = '0; rresp = 0; rlast = 0; rvalid = 0; rid = 0;
    rd_ready = 0; err_clear = 0;
    step(); step();
    arst = 1'b0;
    step();
    clear_log();
  endtask

  // Present one beat and return #1 after the edge that accepts it.
  task automatic send_beat(input int d, input logic [1:0] resp, input logic last,
                           input logic [5:0] id);
    int budget = 50;
    logic ok;
    rdata = 256'(d); rresp = resp; rlast = last; rid = id; rvalid = 1'b1;
    do begin
      ok = rready;
      step();
      budget--;
    end while (!ok && budget > 0);
    if (!ok) begin
      errors++;
      $display("FAIL send_beat timeout: beat %0d never accepted (rready=%b, need 1)", d, rready);
    end
    rvalid = 1'b0;
  endtask

  task automatic issue_ar(input int n);
    ar_issue = 1'b1;
    repeat (n) step();
    ar_issue = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({rd_valid, rd_last, rd_resp, rready, burst_done} !== 6'b0_0_00_1_0) begin
      errors++;
      $display("FAIL reset_flags: got v%b l%b r%b rr%b bd%b, need v0 l0 r00 rr1 bd0",
               rd_valid, rd_last, rd_resp, rready, burst_done);
    end
    checks++;
    if (rd_data !== '0 || outstanding !== 5'd0 || errs !== 5'b0) begin
      errors++;
      $display("FAIL reset_state: got data=%0h outst=%0d errs=%b, need 0 0 00000",
               rd_data, outstanding, errs);
    end
  endtask

  task automatic test_basic_burst();
    do_reset();
    rd_ready = 1'b1;
    issue_ar(1);
    checks++;
    if (outstanding !== 5'd1) begin
      errors++; $display("FAIL basic_outst_issue: got %0d, need 1", outstanding);
    end
    for (int k = 0; k < 16; k++) send_beat(k, 2'b00, k == 15, 6'd0);
    checks++;
    if (burst_done !== 1'b1 || outstanding !== 5'd0) begin
      errors++;
      $display("FAIL basic_done: got bd=%b outst=%0d, need bd=1 outst=0", burst_done, outstanding);
    end
    repeat (3) step();
    checks++;
    if (q_data.size() != 16 || bd_cnt != 1) begin
      errors++;
      $display("FAIL basic_counts: got pops=%0d bd_pulses=%0d, need 16 1", q_data.size(), bd_cnt);
    end
    for (int k = 0; k < q_data.size() && k < 16; k++) begin
      checks++;
      if (q_data[k] !== 32'(k) || q_last[k] !== (k == 15)) begin
        errors++;
        $display("FAIL basic_pop[%0d]: got data=%0d last=%b, need %0d %b",
                 k, q_data[k], q_last[k], k, k == 15);
      end
    end
    checks++;
    if (errs !== 5'b0 || rd_valid !== 1'b0) begin
      errors++; $display("FAIL basic_errs: got errs=%b v=%b, need 00000 0", errs, rd_valid);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    issue_ar(1);
    for (int k = 0; k < 4; k++) send_beat(100 + k, 2'b00, 1'b0, 6'd0);
    checks++;
    if (rready !== 1'b0 || rd_valid !== 1'b1 || rd_data[31:0] !== 32'd100) begin
      errors++;
      $display("FAIL bp_full: got rready=%b v=%b head=%0d, need 0 1 100",
               rready, rd_valid, rd_data[31:0]);
    end
    step();
    checks++;
    if (rready !== 1'b0) begin
      errors++; $display("FAIL bp_hold: got rready=%b, need 0", rready);
    end
    rd_ready = 1'b1;
    for (int k = 4; k < 16; k++) send_beat(100 + k, 2'b00, k == 15, 6'd0);
    repeat (6) step();
    checks++;
    if (q_data.size() != 16) begin
      errors++; $display("FAIL bp_count: got %0d pops, need 16", q_data.size());
    end
    for (int k = 0; k < q_data.size() && k < 16; k++) begin
      checks++;
      if (q_data[k] !== 32'(100 + k)) begin
        errors++; $display("FAIL bp_order[%0d]: got %0d, need %0d", k, q_data[k], 100 + k);
      end
    end
    checks++;
    if (errs !== 5'b0 || outstanding !== 5'd0) begin
      errors++; $display("FAIL bp_end: got errs=%b outst=%0d, need 00000 0", errs, outstanding);
    end
  endtask

  task automatic test_err_last();
    do_reset();
    rd_ready = 1'b1;
    issue_ar(1);
    for (int k = 0; k < 16; k++) begin
      send_beat(k, 2'b00, (k == 7) || (k == 15), 6'd0);
      if (k == 6) begin
        checks++;
        if (err_last !== 1'b0) begin
          errors++; $display("FAIL errlast_early: got %b, need 0", err_last);
        end
      end
      if (k == 7) begin
        checks++;
        if (err_last !== 1'b1) begin
          errors++; $display("FAIL errlast_set: got %b, need 1", err_last);
        end
      end
    end
    checks++;
    if (burst_done !== 1'b1 || outstanding !== 5'd0) begin
      errors++;
      $display("FAIL errlast_close: got bd=%b outst=%0d, need 1 0", burst_done, outstanding);
    end
    repeat (2) step();
    checks++;
    if (q_last.size() != 16 || q_last[7] !== 1'b0 || q_last[15] !== 1'b1) begin
      errors++; $display("FAIL errlast_framing: got pops=%0d, need 16 with last only at 15",
                         q_last.size());
    end
    err_clear = 1'b1;
    step();
    err_clear = 1'b0;
    checks++;
    if (err_last !== 1'b0) begin
      errors++; $display("FAIL errlast_clear: got %b, need 0", err_last);
    end
  endtask

  task automatic test_resp_id();
    do_reset();
    rd_ready = 1'b1;
    issue_ar(1);
    for (int k = 0; k < 16; k++) begin
      if (k == 3) send_beat(k, 2'b10, 1'b0, 6'd5);
      else        send_beat(k, 2'b00, k == 15, 6'd0);
      if (k == 2) begin
        checks++;
        if (errs !== 5'b0) begin
          errors++; $display("FAIL respid_early: got errs=%b, need 00000", errs);
        end
      end
      if (k == 3) begin
        checks++;
        if (errs !== 5'b10100) begin
          errors++; $display("FAIL respid_set: got errs=%b, need 10100", errs);
        end
      end
    end
    repeat (2) step();
    checks++;
    if (q_resp.size() != 16 || q_resp[3] !== 2'b10 || q_resp[2] !== 2'b00) begin
      errors++; $display("FAIL respid_pop: got pops=%0d, need 16 with rd_resp=10 on pop 3",
                         q_resp.size());
    end
  endtask

  task automatic test_unexp_ovf();
    do_reset();
    rd_ready = 1'b1;
    send_beat(77, 2'b00, 1'b0, 6'd0);
    checks++;
    if (errs !== 5'b00010 || rd_valid !== 1'b0) begin
      errors++; $display("FAIL unexp: got errs=%b v=%b, need 00010 0", errs, rd_valid);
    end
    issue_ar(16);
    checks++;
    if (outstanding !== 5'd16 || err_ovf !== 1'b0) begin
      errors++; $display("FAIL ovf_16: got outst=%0d ovf=%b, need 16 0", outstanding, err_ovf);
    end
    issue_ar(1);
    checks++;
    if (outstanding !== 5'd16 || err_ovf !== 1'b1) begin
      errors++; $display("FAIL ovf_17: got outst=%0d ovf=%b, need 16 1", outstanding, err_ovf);
    end
  endtask

  task automatic test_coincide_and_reset();
    do_reset();
    rd_ready = 1'b1;
    issue_ar(2);
    for (int k = 0; k < 15; k++) send_beat(k, 2'b00, 1'b0, 6'd0);
    ar_issue = 1'b1;
    send_beat(15, 2'b00, 1'b1, 6'd0);
    ar_issue = 1'b0;
    checks++;
    if (outstanding !== 5'd2 || burst_done !== 1'b1) begin
      errors++;
      $display("FAIL coincide: got outst=%0d bd=%b, need 2 1", outstanding, burst_done);
    end
    for (int k = 0; k < 9; k++) send_beat(200 + k, 2'b00, 1'b0, 6'd0);
    checks++;
    if (rd_valid !== 1'b1) begin
      errors++; $display("FAIL midburst_pre: got rd_valid=%b, need 1", rd_valid);
    end
    rdata = 256'd209; rvalid = 1'b1; rresp = 2'b00; rlast = 1'b0;
    arst = 1'b1;
    #1;
    checks++;
    if ({rd_valid, rd_last, rd_resp, rready, burst_done} !== 6'b0_0_00_1_0 ||
        rd_data !== '0 || outstanding !== 5'd0 || errs !== 5'b0) begin
      errors++;
      $display("FAIL midburst_reset: got v%b l%b r%b rr%b bd%b outst=%0d errs=%b, need 0 0 00 1 0 0 00000",
               rd_valid, rd_last, rd_resp, rready, burst_done, outstanding, errs);
    end
    rvalid = 1'b0;
    step();
    arst = 1'b0;
    step();
    send_beat(300, 2'b00, 1'b0, 6'd0);
    checks++;
    if (err_unexp !== 1'b1 || rd_valid !== 1'b0) begin
      errors++; $display("FAIL post_reset_unexp: got unexp=%b v=%b, need 1 0", err_unexp, rd_valid);
    end
  endtask

  initial begin
    test_reset();
    test_basic_burst();
    test_backpressure();
    test_err_last();
    test_resp_id();
    test_unexp_ovf();
    test_coincide_and_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
